// File: rtl/ram_loader_pkg.sv
// Shared loader types: FSM state encoding, byte/checksum widths and the checksum rule.
package ram_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CSUM_W = 8;

  typedef logic [CSUM_W-1:0] csum_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Trailer byte that brings the running sum to zero modulo 2**CSUM_W.
  function automatic csum_t csum_expect(input csum_t sum);
    return ~sum + csum_t'(1);
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Host-side byte handshake plus CPU RAM write port and session status.
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int unsigned AW = 4
);

  logic              host_start;
  logic              host_strobe;
  logic [BYTE_W-1:0] host_data;
  logic              host_ack;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output host_start, host_strobe, host_data,
    input  host_ack, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  host_start, host_strobe, host_data,
    output host_ack, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/ram_loader_sync_edge.sv
// Two-flop synchronizer for the asynchronous host strobe plus a rising-edge detector.
module ram_loader_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      edge_q <= sync_q;
    end
  end

  assign level  = sync_q;
  assign rise_c = sync_q & ~edge_q;

endmodule

// File: rtl/ram_loader.sv
// Boot loader: receives NWORDS host bytes into CPU RAM while holding the CPU, then verifies a checksum byte.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned NWORDS = 16,
  parameter int unsigned AW     = 4
) (
  input  logic        clk,
  input  logic        rst,
  ram_loader_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_cnt_q, addr_cnt_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  csum_t             sum_q, sum_d;
  logic [BYTE_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              host_ack_q, host_ack_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              start_q;

  logic strobe_lvl;
  logic strobe_rise_c;
  logic accept_c;
  logic open_c;

  ram_loader_sync_edge sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.host_strobe),
    .level    (strobe_lvl),
    .rise_c   (strobe_rise_c)
  );

  // A byte is taken only on a fresh edge after the previous ack has dropped.
  assign accept_c = strobe_rise_c & ~host_ack_q;

  // IDLE opens on the start level; DONE/ERROR need a fresh 0->1 on host_start.
  assign open_c = ((state_q == ST_IDLE) && bus.host_start) ||
                  (((state_q == ST_DONE) || (state_q == ST_ERROR)) && bus.host_start && !start_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= '0;
      sum_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      host_ack_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      sum_q       <= sum_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      host_ack_q  <= host_ack_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      start_q     <= bus.host_start;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    sum_d       = sum_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    host_ack_d  = host_ack_q & strobe_lvl;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (open_c) begin
          state_d     = ST_RECV;
          addr_cnt_d  = '0;
          sum_d       = '0;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
        end
      end
      ST_RECV: begin
        if (accept_c) begin
          state_d     = ST_WRITE;
          ram_wdata_d = bus.host_data;
          ram_addr_d  = addr_cnt_q;
          ram_we_d    = 1'b1;
          host_ack_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        sum_d = sum_q + ram_wdata_q;
        if (addr_cnt_q < LAST_ADDR) begin
          addr_cnt_d = addr_cnt_q + AW'(1);
          state_d    = ST_RECV;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Trailer byte is compared only, never written to RAM.
        if (accept_c) begin
          host_ack_d = 1'b1;
          if (bus.host_data == csum_expect(sum_q)) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.host_ack  = host_ack_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed and randomized load sessions for ram_loader, checked against a byte-list/checksum model.
module tb_ram_loader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   wr_addr[$];
  int   wr_data[$];

  ram_loader_if #(.AW(4)) bus ();

  ram_loader #(.NWORDS(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write pulse mid-cycle.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wr_addr.push_back(int'(bus.ram_addr));
      wr_data.push_back(int'(bus.ram_wdata));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int i = 0;
    while (bus.host_ack !== lvl && i < 20) begin
      step();
      i++;
    end
    check(tag, 32'(bus.host_ack), 32'(lvl));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.host_data   = b;
    bus.host_strobe = 1'b1;
    wait_ack(1'b1, "ack_set");
    bus.host_strobe = 1'b0;
    wait_ack(1'b0, "ack_clr");
  endtask

  task automatic start_session();
    wr_addr.delete();
    wr_data.delete();
    bus.host_start = 1'b1;
    step();
    check("start_hold", 32'(bus.cpu_hold), 32'd1);
    check("start_done", 32'(bus.load_done), 32'd0);
    check("start_err", 32'(bus.load_err), 32'd0);
    bus.host_start = 1'b0;
    step();
  endtask

  // Full session: 16 data bytes then a trailer; outcome follows (sum + trailer) % 256 == 0.
  task automatic load(input logic [7:0] d[16], input logic [7:0] cs, input string tag);
    int sum = 0;
    bit good;
    start_session();
    for (int i = 0; i < 16; i++) begin
      send_byte(d[i]);
      sum += int'(d[i]);
      if (i == 3) begin
        bus.host_start = 1'b1;
        step();
        bus.host_start = 1'b0;
      end
    end
    send_byte(cs);
    step(2);
    good = ((sum + int'(cs)) % 256) == 0;
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("%s_wr%0d_data", tag, i), 32'(wr_data[i]), 32'(d[i]));
      end
    end
    check({tag, "_done"}, 32'(bus.load_done), 32'(good));
    check({tag, "_err"}, 32'(bus.load_err), 32'(!good));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!good));
  endtask

  initial begin
    logic [7:0] d[16];
    int         sum;
    int         n_before;
    logic [7:0] cs;

    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.host_start  = 1'b0;
    bus.host_strobe = 1'b0;
    bus.host_data   = 8'h00;
    step(3);
    check("rst_we", 32'(bus.ram_we), 32'd0);
    check("rst_ack", 32'(bus.host_ack), 32'd0);
    check("rst_done", 32'(bus.load_done), 32'd0);
    check("rst_err", 32'(bus.load_err), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_hold", 32'(bus.cpu_hold), 32'd1);
    rst = 1'b0;
    step();

    // Directed good load: 0x01..0x10 sum to 0x88, trailer 0x78.
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    load(d, 8'h78, "full");

    // Strobe activity in DONE must be ignored.
    n_before        = wr_addr.size();
    bus.host_strobe = 1'b1;
    step(6);
    check("done_strobe_ack", 32'(bus.host_ack), 32'd0);
    check("done_strobe_nwr", 32'(wr_addr.size()), 32'(n_before));
    bus.host_strobe = 1'b0;
    step(4);
    check("done_hold_state", 32'(bus.load_done), 32'd1);

    // Restart from DONE with a bad trailer.
    load(d, 8'h00, "badcs");

    // Latency and held-strobe behaviour, restarting from ERROR.
    start_session();
    bus.host_data   = 8'hA5;
    bus.host_strobe = 1'b1;
    step();
    check("lat_we_n1", 32'(bus.ram_we), 32'd0);
    step();
    check("lat_we_n2", 32'(bus.ram_we), 32'd0);
    step();
    check("lat_we_n3", 32'(bus.ram_we), 32'd1);
    check("lat_addr", 32'(bus.ram_addr), 32'd0);
    check("lat_data", 32'(bus.ram_wdata), 32'hA5);
    check("lat_ack", 32'(bus.host_ack), 32'd1);
    step();
    check("lat_we_n4", 32'(bus.ram_we), 32'd0);
    step(6);
    check("held_nwr", 32'(wr_addr.size()), 32'd1);
    check("held_ack", 32'(bus.host_ack), 32'd1);
    bus.host_strobe = 1'b0;
    step();
    check("ack_low_p1", 32'(bus.host_ack), 32'd1);
    step();
    check("ack_low_p2", 32'(bus.host_ack), 32'd1);
    step();
    check("ack_low_p3", 32'(bus.host_ack), 32'd0);
    send_byte(8'h3C);
    check("second_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("second_addr", 32'(wr_addr[1]), 32'd1);
      check("second_data", 32'(wr_data[1]), 32'h3C);
    end
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));

    // Reset with a byte in flight: nothing stale may reach the RAM.
    check("pre_rst_nwr", 32'(wr_addr.size()), 32'd5);
    bus.host_data   = 8'h77;
    bus.host_strobe = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_hold", 32'(bus.cpu_hold), 32'd1);
    check("midrst_addr", 32'(bus.ram_addr), 32'd0);
    check("midrst_we", 32'(bus.ram_we), 32'd0);
    check("midrst_ack", 32'(bus.host_ack), 32'd0);
    step(6);
    bus.host_strobe = 1'b0;
    step(4);
    check("midrst_nwr", 32'(wr_addr.size()), 32'd5);

    // Randomized sessions, alternating correct and corrupted trailers.
    for (int s = 0; s < 4; s++) begin
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        d[i] = 8'($urandom);
        sum += int'(d[i]);
      end
      cs = 8'((256 - (sum % 256)) % 256);
      if (s % 2 == 1) cs = cs ^ 8'($urandom_range(1, 255));
      load(d, cs, $sformatf("rand%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
